// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the block-RAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned IDX_W   = $clog2(MAX_REQ);

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) idx = idx | IDX_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after the last winner.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_REQ-1:0] req_x;
    logic [MAX_REQ-1:0] gnt_x;
    logic [IDX_W-1:0]   pos;

    always_comb begin
        req_x = MAX_REQ'(req);
        gnt_x = '0;
        pos   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            pos = IDX_W'((32'(last) + i) % N_REQ);
            if (gnt_x == '0 && req_x[pos]) gnt_x[pos] = 1'b1;
        end
    end

    assign gnt = N_REQ'(gnt_x);
    assign idx = onehot_to_idx(gnt_x);
    assign any = |gnt_x;

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between requesters, with
// an exclusive lock for read-modify-write sequences and a 1-cycle read return.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            lock_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] din_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        bram_we_o,
    output logic [ADDR_WIDTH-1:0]       bram_addr_o,
    output logic [DATA_WIDTH-1:0]       bram_din_o,
    input  logic [DATA_WIDTH-1:0]       bram_dout_i
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] owner_q;
    logic             owner_vld_q;
    logic [N_REQ-1:0] rd_pend_q;

    logic [N_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_any;

    logic [MAX_REQ-1:0]    req_x;
    logic [MAX_REQ-1:0]    lock_x;
    logic [MAX_REQ-1:0]    we_x;
    logic [ADDR_WIDTH-1:0] addr_arr [MAX_REQ];
    logic [DATA_WIDTH-1:0] din_arr  [MAX_REQ];

    logic             locked_c;
    logic             any_c;
    logic [IDX_W-1:0] win_c;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req_i),
        .last (last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // Widen per-requester fields to MAX_REQ so any index width is safe.
    always_comb begin
        req_x  = MAX_REQ'(req_i);
        lock_x = MAX_REQ'(lock_i);
        we_x   = MAX_REQ'(we_i);
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            addr_arr[k] = '0;
            din_arr[k]  = '0;
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            addr_arr[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            din_arr[k]  = din_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A held lock overrides round-robin; only the owner can be granted.
    always_comb begin
        locked_c = owner_vld_q && lock_x[owner_q];
        any_c    = rr_any;
        win_c    = rr_idx;
        gnt_o    = rr_gnt;
        if (locked_c) begin
            any_c = req_x[owner_q];
            win_c = owner_q;
            gnt_o = any_c ? N_REQ'(MAX_REQ'(1) << owner_q) : '0;
        end
    end

    assign bram_we_o   = any_c & we_x[win_c];
    assign bram_addr_o = any_c ? addr_arr[win_c] : addr_arr[0];
    assign bram_din_o  = any_c ? din_arr[win_c]  : din_arr[0];

    assign rvalid_o = rd_pend_q;
    assign rdata_o  = bram_dout_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            rd_pend_q   <= '0;
        end else begin
            if (any_c && !locked_c) last_q <= win_c;
            if (!locked_c) begin
                owner_vld_q <= any_c && lock_x[win_c];
                owner_q     <= win_c;
            end
            rd_pend_q <= (any_c && !we_x[win_c]) ? gnt_o : '0;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter against an integer-level model.
module tb_bram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] din;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, bram_din, bram_dout;
    logic            bram_we;
    logic [AW-1:0]   bram_addr;

    logic [DW-1:0] ram   [1024];
    logic [DW-1:0] m_mem [1024];
    int            m_last, m_owner, m_pend;
    logic [DW-1:0] m_pdata;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            s_g;
    logic [N-1:0]  s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    bit            act [N];

    always #5 clk = ~clk;

    // Block RAM with registered read output
    always @(posedge clk) begin
        if (bram_we) ram[bram_addr] <= bram_din;
        bram_dout <= ram[bram_addr];
    end

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .din_i       (din),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .bram_we_o   (bram_we),
        .bram_addr_o (bram_addr),
        .bram_din_o  (bram_din),
        .bram_dout_i (bram_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        int p;
        if (m_owner >= 0 && lock[m_owner]) return req[m_owner] ? m_owner : -1;
        for (int i = 1; i <= N; i++) begin
            p = (m_last + i) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[k]              = w;
        addr[k*AW +: AW]   = a;
        din[k*DW +: DW]    = d;
    endtask

    // Checks one cycle at the falling edge, then advances the model.
    task automatic tick();
        int g;
        bit locked;
        @(negedge clk);
        g        = exp_grant();
        s_g      = g;
        s_gnt    = gnt;
        s_rvalid = rvalid;
        s_rdata  = rdata;
        check("gnt", 32'(gnt), g >= 0 ? 32'(1) << g : 32'(0));
        check("bram_we", 32'(bram_we), (g >= 0 && we[g]) ? 32'(1) : 32'(0));
        if (g >= 0) begin
            check("bram_addr", 32'(bram_addr), 32'(addr[g*AW +: AW]));
            check("bram_din", 32'(bram_din), 32'(din[g*DW +: DW]));
        end
        check("rvalid", 32'(rvalid), m_pend >= 0 ? 32'(1) << m_pend : 32'(0));
        if (m_pend >= 0) check("rdata", 32'(rdata), 32'(m_pdata));
        locked = (m_owner >= 0 && lock[m_owner]);
        m_pend = -1;
        if (g >= 0) begin
            if (!locked) m_last = g;
            if (we[g]) m_mem[addr[g*AW +: AW]] = din[g*DW +: DW];
            else begin
                m_pend  = g;
                m_pdata = m_mem[addr[g*AW +: AW]];
            end
        end
        if (!locked) m_owner = (g >= 0 && lock[g]) ? g : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_bram_we", 32'(bram_we), 32'(0));
        m_last  = N - 1;
        m_owner = -1;
        m_pend  = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = DW'($urandom);
            m_mem[i] = ram[i];
        end
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; din = '0;
        do_reset();

        // Single read with 1-cycle return
        ram[5] = 16'hBEEF; m_mem[5] = 16'hBEEF;
        req = 2'b01; set_req(0, 1'b0, AW'(5), '0);
        tick(); check("t1_gnt", 32'(s_gnt), 32'h1);
        req = 2'b00;
        tick(); check("t1_rvalid", 32'(s_rvalid), 32'h1); check("t1_rdata", 32'(s_rdata), 32'hBEEF);

        // Alternation from reset
        do_reset();
        req = 2'b11; set_req(0, 1'b0, AW'(1), '0); set_req(1, 1'b0, AW'(2), '0);
        for (int i = 0; i < 4; i++) begin
            tick(); check("t2_gnt", 32'(s_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        req = 2'b00; tick();

        // Write then read same address
        req = 2'b10; set_req(1, 1'b1, AW'(7), 16'h1234);
        tick(); check("t3_wgnt", 32'(s_gnt), 32'h2);
        req = 2'b01; set_req(0, 1'b0, AW'(7), '0);
        tick(); check("t3_rgnt", 32'(s_gnt), 32'h1);
        req = 2'b00;
        tick(); check("t3_rvalid", 32'(s_rvalid), 32'h1); check("t3_rdata", 32'(s_rdata), 32'h1234);

        // Lock by requester 1, then release
        req = 2'b10; lock = 2'b10; set_req(1, 1'b0, AW'(3), '0);
        tick(); check("t4_acq", 32'(s_gnt), 32'h2);
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick(); check("t4_locked", 32'(s_gnt), 32'h2);
        end
        lock = 2'b00;
        tick(); check("t4_release", 32'(s_gnt), 32'h1);
        req = 2'b00; tick();

        // Owner idles while holding lock
        req = 2'b10; lock = 2'b10;
        tick(); check("t5_acq", 32'(s_gnt), 32'h2);
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick(); check("t5_idle", 32'(s_gnt), 32'h0);
        end
        lock = 2'b00;
        tick(); check("t5_release", 32'(s_gnt), 32'h1);
        req = 2'b00; tick();

        // Reset right after a locked read
        req = 2'b10; lock = 2'b10; set_req(1, 1'b0, AW'(9), '0);
        tick(); check("t6_gnt", 32'(s_gnt), 32'h2);
        do_reset();
        req = 2'b11; lock = 2'b10;
        tick(); check("t6_post_rst", 32'(s_gnt), 32'h1);
        tick(); check("t6_second", 32'(s_gnt), 32'h2);
        req = 2'b00; lock = 2'b00; tick();

        // Random traffic obeying hold-until-granted
        for (int k = 0; k < N; k++) act[k] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            for (int k = 0; k < N; k++) begin
                if (!act[k] && $urandom_range(0, 1) == 1) begin
                    act[k] = 1'b1;
                    set_req(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
                end
                if ($urandom_range(0, 5) == 0) lock[k] = ~lock[k];
                req[k] = act[k];
            end
            tick();
            if (s_g >= 0) act[s_g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of a dual-port block RAM between N_REQ requesters in the bin manager, such as the bin loader, bin saver and conflict-analysis reader. It grants at most one access per cycle and drives the RAM port. Read data is returned to the granted requester with a per-requester valid strobe. A lock lets one requester hold the port exclusively for multi-cycle read-modify-write sequences.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 10, RAM address width
- N_REQ, 2, number of requesters (2..4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  N_REQ  access request, one bit per requester
- lock_i  in  N_REQ  hold port ownership after grant
- we_i  in  N_REQ  1 = write, 0 = read
- addr_i  in  N_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- din_i  in  N_REQ*DATA_WIDTH  packed write data
- gnt_o  out  N_REQ  one-hot grant (combinational, same cycle as request)
- rvalid_o  out  N_REQ  read data valid for requester k
- rdata_o  out  DATA_WIDTH  read data (common to all requesters)
- bram_we_o  out  1  RAM write enable
- bram_addr_o  out  ADDR_WIDTH  RAM address
- bram_din_o  out  DATA_WIDTH  RAM write data
- bram_dout_i  in  DATA_WIDTH  RAM registered read output

## Operation
- State registers:
  - last_q (index of the last winner)
  - owner_q (lock owner index) and owner_vld_q
  - rd_pend_q (one-hot requester of the read issued last cycle)
- Unlocked arbitration: scan req_i starting at last_q+1 modulo N_REQ; the first set bit wins. Update last_q to the winner on every grant.
- Locked arbitration, when owner_vld_q=1 and lock_i[owner_q]=1:
  - only the owner may be granted; other requests stall;
  - the owner may idle with req low while holding lock;
  - last_q is not updated.
- Lock acquire: the granted requester has lock_i=1 in its grant cycle. owner_q is set to it and owner_vld_q=1 from the next cycle.
- Lock release: lock_i[owner_q]=0. owner_vld_q clears at the next edge. Arbitration in that same cycle is already unlocked and round-robin.
- Port drive:
  - with a grant: bram_we_o=we_i[g], bram_addr_o=addr_i[g], bram_din_o=din_i[g];
  - without a grant: bram_we_o=0, and address/data hold the requester-0 values (don't-care).
- Read return: a granted read sets rd_pend_q=onehot(g). rvalid_o=rd_pend_q, and rdata_o=bram_dout_i passes through combinationally.
- Writes produce no rvalid.
- A read granted the cycle after a write to the same address returns the new data.
- A requester holds req/we/addr/din stable until it sees gnt_o. After gnt_o it may change them the next cycle.

## Timing
- Grant: 0-cycle, combinational from req_i and the state registers.
- Read latency: rvalid_o and rdata_o are valid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle; back-to-back reads from different requesters are allowed.
- Reset values:
  - gnt_o=0, rvalid_o=0, bram_we_o=0
  - last_q=N_REQ-1, so requester 0 has priority first
  - owner_vld_q=0, rd_pend_q=0
- Reset asserted mid-read: the pending rvalid is dropped and any lock is released.
- Boundary cases:
  - all req low: no grant, last_q unchanged;
  - lock_i asserted while not granted: ignored;
  - lock owner requests while others request: the owner wins every cycle.

## Structure
- Package bram_arb_pkg: constant MAX_REQ=4, plus function onehot_to_idx.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, winner index, any flag.
- The lock override and the pending-read pipeline live in the top module.

## Test plan
- Reset, then req_i=2'b01 read addr 5 with RAM[5]=16'hBEEF → gnt_o=01 in the same cycle; next cycle rvalid_o=01 and rdata_o=BEEF.
- req_i=2'b11 held for 4 cycles → grants alternate 01,10,01,10, starting with 01 after reset.
- Requester 1 writes 16'h1234 to addr 7; next cycle requester 0 reads addr 7 → rvalid_o=01 and rdata_o=1234 one cycle later.
- Requester 1 acquires lock, then req_i=11 for 3 cycles → only gnt_o=10 each cycle. After lock_i[1] drops, requester 0 is granted in the same cycle.
- Lock owner idles with req low and lock high while requester 0 requests → gnt_o=00 for every held cycle.
- Assert rst the cycle after a granted read → rvalid_o=0 and no lock remains. The first post-reset grant with req_i=11 goes to requester 0.
